// File: rtl/tff_seq_ctrl_if.sv
// Host-side bundle for the T-FF run-length sequencer: launch/stall controls in,
// counter state and status pulses out.
interface tff_seq_ctrl_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
);
  logic              start;
  logic [STEP_W-1:0] steps;
  logic              up;
  logic [WIDTH-1:0]  mod_val;
  logic              hold;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              wrap;
  logic              done;

  modport master (
    output start, steps, up, mod_val, hold,
    input  count, busy, wrap, done
  );

  modport slave (
    input  start, steps, up, mod_val, hold,
    output count, busy, wrap, done
  );
endinterface

// File: rtl/tff_seq_ctrl.sv
// Steps a T-FF modulo up/down counter for N launched steps; busy one edge after launch,
// done/wrap registered one cycle after the causing edge; hold stalls with a one-cycle resume bubble.
module tff_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  tff_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_step;
  logic [WIDTH-1:0]  t;
  logic [WIDTH-1:0]  top_val;
  logic [WIDTH-1:0]  mod_r;
  logic              up_r;
  logic [STEP_W-1:0] rem;
  logic [STEP_W-1:0] rem_nxt;
  logic              step_en;
  logic              step_wrap;
  logic              launch;
  logic              done_nxt;
  logic              wrap_r;
  logic              done_r;

  // mod_r == 0 wraps to all-ones here, which is exactly the full-range top value.
  assign top_val = mod_r - WIDTH'(1);

  always_comb begin
    q_step    = q;
    step_wrap = 1'b0;
    if (q > top_val) begin
      q_step    = '0;
      step_wrap = 1'b1;
    end else if (up_r) begin
      if (q == top_val) begin
        q_step    = '0;
        step_wrap = 1'b1;
      end else begin
        q_step = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        q_step    = top_val;
        step_wrap = 1'b1;
      end else begin
        q_step = q - WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    step_en   = 1'b0;
    launch    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.steps != '0) begin
            launch    = 1'b1;
            rem_nxt   = bus.steps;
            state_nxt = RUN;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.hold) begin
          state_nxt = HOLD;
        end else begin
          step_en = 1'b1;
          rem_nxt = rem - STEP_W'(1);
          if (rem == STEP_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      HOLD: begin
        // Leaving HOLD costs one edge with no step.
        if (!bus.hold) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Toggle enables only for bits that differ; all-zero when not stepping.
  assign t = step_en ? (q ^ q_step) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      q      <= '0;
      rem    <= '0;
      up_r   <= 1'b0;
      mod_r  <= '0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q ^ t;
      rem    <= rem_nxt;
      wrap_r <= step_en & step_wrap;
      done_r <= done_nxt;
      if (launch) begin
        up_r  <= bus.up;
        mod_r <= bus.mod_val;
      end
    end
  end

  assign bus.count = q;
  assign bus.busy  = (state != IDLE);
  assign bus.wrap  = wrap_r;
  assign bus.done  = done_r;

endmodule
